// File: rtl/i2s_audio_tx_if.sv
// Audio sample input and I2S pin bundle for i2s_audio_tx.
// The master side is the transmitter: it takes samples in and drives the pins.
interface i2s_audio_tx_if;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        sample_ack;
    logic        I2S_BCK;
    logic        I2S_LRCK;
    logic        I2S_DATA;

    modport master (
        input  left_chan,
        input  right_chan,
        output sample_ack,
        output I2S_BCK,
        output I2S_LRCK,
        output I2S_DATA
    );

    modport slave (
        output left_chan,
        output right_chan,
        input  sample_ack,
        input  I2S_BCK,
        input  I2S_LRCK,
        input  I2S_DATA
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// Philips I2S stereo transmitter: 16-bit samples in 32-bit slots, 64*fs bit clock
// derived from clk_sys by a phase accumulator with exact long-run average.
module i2s_audio_tx #(
    parameter int unsigned CLK_RATE    = 50_000_000,
    parameter int unsigned SAMPLE_RATE = 48_000
) (
    input logic            clk_sys,
    input logic            reset_n,
    i2s_audio_tx_if.master aud_io
);

    localparam logic [31:0] Step    = 32'(SAMPLE_RATE * 128);
    localparam logic [31:0] ClkRate = 32'(CLK_RATE);

    if (SAMPLE_RATE * 128 > CLK_RATE) begin : g_rate_check
        $error("i2s_audio_tx: SAMPLE_RATE*128 must not exceed CLK_RATE");
    end

    logic [31:0] acc_q, acc_d;
    logic        bck_q, bck_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic        ack_q, ack_d;

    logic [31:0] acc_sum;
    logic        tick;
    logic        fall_tick;
    logic        wrap;
    logic [5:0]  cnt_inc;
    logic [4:0]  slot_pos;
    logic [3:0]  bit_idx;
    logic [15:0] slot_word;
    logic        slot_bit;

    // acc < CLK_RATE < 2^31 and Step <= CLK_RATE, so the sum cannot overflow 32 bits.
    assign acc_sum   = acc_q + Step;
    assign tick      = (acc_sum >= ClkRate);
    assign fall_tick = tick & bck_q;
    assign cnt_inc   = cnt_q + 6'd1;
    assign wrap      = fall_tick && (cnt_q == 6'd63);

    // Slot bit for the count about to be entered; position 0 is the one-BCK I2S delay.
    always_comb begin
        slot_pos  = cnt_inc[4:0];
        bit_idx   = 4'(5'd16 - slot_pos);
        slot_word = cnt_inc[5] ? hold_r_q : hold_l_q;
        slot_bit  = 1'b0;
        if ((slot_pos != 5'd0) && (slot_pos <= 5'd16)) begin
            slot_bit = slot_word[bit_idx];
        end
    end

    always_comb begin
        acc_d    = tick ? (acc_sum - ClkRate) : acc_sum;
        bck_d    = bck_q ^ tick;
        cnt_d    = cnt_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        ack_d    = wrap;
        if (fall_tick) begin
            cnt_d  = cnt_inc;
            lrck_d = cnt_inc[5];
            data_d = slot_bit;
        end
        if (wrap) begin
            hold_l_d = aud_io.left_chan;
            hold_r_d = aud_io.right_chan;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_q    <= '0;
            bck_q    <= 1'b0;
            cnt_q    <= '0;
            lrck_q   <= 1'b0;
            data_q   <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            bck_q    <= bck_d;
            cnt_q    <= cnt_d;
            lrck_q   <= lrck_d;
            data_q   <= data_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            ack_q    <= ack_d;
        end
    end

    assign aud_io.sample_ack = ack_q;
    assign aud_io.I2S_BCK    = bck_q;
    assign aud_io.I2S_LRCK   = lrck_q;
    assign aud_io.I2S_DATA   = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: an integer-ratio instance checked frame by frame against a
// queue of expected frames, and a fractional-rate instance checked for tick statistics.
module tb_i2s_audio_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic rst_f_n = 1'b0;

    i2s_audio_tx_if a_if ();
    i2s_audio_tx_if f_if ();

    i2s_audio_tx #(
        .CLK_RATE   (1280),
        .SAMPLE_RATE(5)
    ) dut_a (
        .clk_sys(clk),
        .reset_n(rst_n),
        .aud_io (a_if)
    );

    i2s_audio_tx #(
        .CLK_RATE   (50_000_000),
        .SAMPLE_RATE(48_000)
    ) dut_f (
        .clk_sys(clk),
        .reset_n(rst_f_n),
        .aud_io (f_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin-level frame image: bit 63 is slot position 0 of the left slot.
    function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
    endfunction

    // ---------------- integer-ratio instance monitor ----------------
    localparam int HalfA  = 2;
    localparam int FrameA = 256;

    logic        rst_q   = 1'b1;
    logic        armed_a = 1'b0;
    int          cyc, last_tog, last_ack, rcount, pos;
    int          nframes = 0;
    logic        prev_bck;
    logic [63:0] frame_bits;
    logic [63:0] exp_q[$];
    logic [63:0] exp_frame;

    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
        if (!rst_q) begin
            armed_a = 1'b1;
            chk("rst_outputs", 64'({a_if.sample_ack, a_if.I2S_BCK, a_if.I2S_LRCK, a_if.I2S_DATA}),
                64'd0);
            cyc        = 0;
            last_tog   = 0;
            last_ack   = 0;
            rcount     = 0;
            prev_bck   = 1'b0;
            frame_bits = '0;
            exp_q.delete();
            exp_q.push_back(64'd0);
        end else if (armed_a) begin
            cyc++;
            if (cyc == 1) begin
                chk("pre_tick_outputs",
                    64'({a_if.sample_ack, a_if.I2S_BCK, a_if.I2S_LRCK, a_if.I2S_DATA}), 64'd0);
            end
            if (a_if.I2S_BCK !== prev_bck) begin
                chk("bck_half_period", 64'(cyc - last_tog), 64'(HalfA));
                last_tog = cyc;
                if (a_if.I2S_BCK === 1'b1) begin
                    pos = rcount % 64;
                    chk("lrck_at_rise", 64'(a_if.I2S_LRCK), 64'(pos >= 32));
                    frame_bits[63-pos] = a_if.I2S_DATA;
                    rcount++;
                    if (pos == 63) begin
                        chk("frame_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            exp_frame = exp_q.pop_front();
                            chk("frame_data", frame_bits, exp_frame);
                            nframes++;
                        end
                    end
                end
                prev_bck = a_if.I2S_BCK;
            end
            if (a_if.sample_ack === 1'b1) begin
                chk("ack_spacing", 64'(cyc - last_ack), 64'(FrameA));
                last_ack = cyc;
                exp_q.push_back(mk_frame(a_if.left_chan, a_if.right_chan));
            end
        end
    end

    // ---------------- fractional-rate instance monitor ----------------
    localparam longint FracN     = 50_000;
    localparam longint FracStep  = 48_000 * 128;
    localparam longint FracClk   = 50_000_000;

    logic   rst_fq  = 1'b1;
    logic   armed_f = 1'b0;
    logic   f_done  = 1'b0;
    logic   fprev;
    int     fcyc, flast, ftog, facks, fd;

    always @(posedge clk) rst_fq <= rst_f_n;

    always @(negedge clk) begin
        if (!rst_fq) begin
            armed_f = 1'b1;
            fcyc    = 0;
            flast   = 0;
            ftog    = 0;
            facks   = 0;
            fprev   = 1'b0;
        end else if (armed_f && !f_done) begin
            fcyc++;
            if (f_if.I2S_BCK !== fprev) begin
                fd = fcyc - flast;
                chk("frac_half_8_or_9", 64'((fd == 8) || (fd == 9)), 64'd1);
                flast = fcyc;
                ftog++;
                fprev = f_if.I2S_BCK;
            end
            if (f_if.sample_ack === 1'b1) facks++;
            if (longint'(fcyc) == FracN) begin
                chk("frac_toggle_count", 64'(ftog), 64'(FracN * FracStep / FracClk));
                chk("frac_ack_count", 64'((facks >= 47) && (facks <= 49)), 64'd1);
                f_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((a_if.sample_ack !== 1'b1) && (n < 1000));
        chk(tag, 64'(a_if.sample_ack), 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        a_if.left_chan  = 16'hAAAA;
        a_if.right_chan = 16'h5555;
        f_if.left_chan  = 16'hC3A5;
        f_if.right_chan = 16'h0F0F;
        rst_n   = 1'b0;
        rst_f_n = 1'b0;
        cycles(5);
        rst_n   = 1'b1;
        rst_f_n = 1'b1;

        // First frame carries zeros; AAAA/5555 latched at the first wrap.
        wait_ack("ack_first");
        cycles(64);
        a_if.left_chan  = 16'h8001;
        a_if.right_chan = 16'h7FFE;
        wait_ack("ack_framing");

        // Halfway through the left slot: must not disturb the frame in flight.
        cycles(64);
        a_if.left_chan = 16'h1234;
        wait_ack("ack_mid_change");
        wait_ack("ack_steady");

        // Reset during the right slot.
        cycles(160);
        rst_n           = 1'b0;
        a_if.left_chan  = 16'hFFFF;
        a_if.right_chan = 16'h0001;
        cycles(3);
        rst_n = 1'b1;
        wait_ack("ack_after_reset");
        wait_ack("ack_after_reset_2");
        cycles(4);
        chk("frames_checked", 64'(nframes), 64'd6);

        n = 0;
        while (!f_done && (n < 60_000)) begin
            @(posedge clk);
            n++;
        end
        chk("frac_window_done", 64'(f_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
# i2s_audio_tx

Serialises the Laser310 core's 16-bit stereo audio into a Philips-format I2S stream on the `I2S_BCK`, `I2S_LRCK` and `I2S_DATA` board pins, instantiated in the board top next to the guest core when `I2S_AUDIO` is defined. It sits directly downstream of the core's audio mixer. A phase accumulator derives an exact-average bit clock (64 × fs) from the system clock. Each frame holds two 32-bit slots, and each slot carries a 16-bit sample, MSB first, padded with zeros.

## Interface
- `CLK_RATE`, 50_000_000: clk_sys frequency in Hz; must be < 2^31.
- `SAMPLE_RATE`, 48_000: output frame rate fs in Hz; requires SAMPLE_RATE×128 ≤ CLK_RATE (elaboration-time assertion).
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `left_chan`  in  16  left sample, two's complement; transmitted as-is.
- `right_chan`  in  16  right sample, two's complement.
- `sample_ack`  out  1  one-cycle pulse: both inputs were latched for the frame now starting.
- `I2S_BCK`  out  1  bit clock, 64×fs average.
- `I2S_LRCK`  out  1  word select: 0 = left slot, 1 = right slot.
- `I2S_DATA`  out  1  serial data; changes on BCK falling edge; receiver samples it on the rising edge.

## Operation
- Constants:
  - STEP = SAMPLE_RATE×128.
  - `acc` is a 32-bit unsigned accumulator.
- Every clk_sys cycle:
  - If acc+STEP ≥ CLK_RATE: acc ← acc+STEP−CLK_RATE and `tick`=1.
  - Otherwise: acc ← acc+STEP and `tick`=0.
- On `tick`, `I2S_BCK` toggles.
- A tick that takes BCK 1→0 is a falling tick. On a falling tick:
  - `cnt` (6-bit) increments mod 64.
  - `I2S_LRCK` ← new cnt[5].
  - `I2S_DATA` is updated from the new cnt.
- Slot position p = cnt[4:0]. Channel source is `hold_l` when cnt[5]=0, otherwise `hold_r`.
  - `I2S_DATA` = hold bit (16−p) for p = 1..16.
  - `I2S_DATA` = 0 for p = 0 and p = 17..31.
  - This gives the one-BCK I2S delay after each LRCK edge.
- On the falling tick where cnt wraps 63→0:
  - `hold_l` ← `left_chan` and `hold_r` ← `right_chan` (values sampled in that same cycle).
  - `sample_ack` is high in the following cycle for exactly one cycle.
- Input changes at any other time do not affect the frame being transmitted.
- A rising tick only changes BCK; LRCK and DATA are stable across it.

## Timing
- Reset (reset_n=0 at a clk_sys edge), next cycle:
  - acc=0, cnt=0, hold_l=hold_r=0.
  - I2S_BCK=0, I2S_LRCK=0, I2S_DATA=0, sample_ack=0.
- Reset asserted mid-frame aborts the frame immediately. There is no partial-slot completion.
- After reset the first frame transmits zeros.
- The first latch of inputs is the first 63→0 wrap, i.e. 64 BCK periods after release.
- All outputs are registered. There is no combinational path from inputs to pins.
- Tick spacing:
  - BCK half-period is ⌊CLK_RATE/STEP⌋ or ⌈CLK_RATE/STEP⌉ clk_sys cycles.
  - Long-run average is exact, with no cumulative drift.
  - If STEP = CLK_RATE, BCK toggles every cycle.
- Latency, input to pin:
  - Inputs are latched at the frame start.
  - The MSB of left appears on `I2S_DATA` one BCK period later.
  - The MSB of right appears 33 BCK periods after the frame start.
- `sample_ack` rate is exactly fs on average. There are 64 BCK periods between consecutive pulses.

## Test plan
- **Reset:** hold reset_n=0 for 5 cycles with non-zero inputs, then release.
  - Required: all outputs 0 through reset and until the first tick.
  - Required: the first frame's DATA is all zeros.
- **Basic timing** (CLK_RATE=1280, SAMPLE_RATE=5, so STEP=640):
  - Required: BCK toggles every 2 clk_sys, period 4.
  - Required: LRCK period is 256 cycles, high for 128.
  - Required: sample_ack pulses every 256 cycles.
- **Data framing:** left=0x8001, right=0x7FFE.
  - Left slot bits sampled on BCK rising edges: 0, 1000_0000_0000_0001, then 15 zeros.
  - Right slot bits: 0, 0111_1111_1111_1110, then 15 zeros.
- **Mid-frame input change:** change left to 0x1234 halfway through the left slot.
  - Required: the current frame still carries the old value.
  - Required: 0x1234 appears in the next frame, after the next sample_ack.
- **Fractional rate** (CLK_RATE=50_000_000, SAMPLE_RATE=48_000, STEP=6_144_000):
  - Required: every BCK half-period is 8 or 9 cycles.
  - Required: exactly 48000 sample_ack pulses in 50_000_000 cycles (±1).
- **Reset mid-frame:** drop reset_n for 3 cycles during the right slot.
  - Required: outputs read 0 on the next edge.
  - Required: after release, cnt restarts at 0 with LRCK=0 and the holding registers cleared.
